base_transpose_stream: RTL and testbench

BASE_TRANSPOSE_STREAM -- requirements
Module: base_transpose_stream

---
 rtl/base_transpose_stream.sv | 125 ++++++++++++
 tb/tb_base_transpose_stream.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module      : base_transpose_stream
// Description : Double-banked streaming matrix transpose. Rows of cs elements
//               fill one bank while columns of rs elements drain the other.
// Revision    : 1.0 - initial release
// ============================================================================

module base_transpose_stream #(
    parameter int w  = 1,
    parameter int rs = 2,
    parameter int cs = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_v,
    output logic              i_r,
    input  logic [0:w*cs-1]   i_d,
    output logic              o_v,
    input  logic              o_r,
    output logic [0:w*rs-1]   o_d,
    output logic              o_last
);

    // Counter widths stay at least one bit so rs == 1 / cs == 1 remain legal.
    localparam int c_rw = (rs > 1) ? $clog2(rs) : 1;
    localparam int c_cw = (cs > 1) ? $clog2(cs) : 1;

    localparam logic [c_rw-1:0] c_row_last = c_rw'(rs - 1);
    localparam logic [c_cw-1:0] c_col_last = c_cw'(cs - 1);
    localparam logic [c_rw-1:0] c_row_one  = c_rw'(1);
    localparam logic [c_cw-1:0] c_col_one  = c_cw'(1);

    logic [0:w-1]      r_mem [0:1][0:rs-1][0:cs-1];
    logic [1:0]        r_full;
    logic              r_wptr;
    logic              r_rptr;
    logic [c_rw-1:0]   r_row;
    logic [c_cw-1:0]   r_col;

    logic              w_wr;
    logic              w_rd;
    logic              w_wr_last;
    logic              w_rd_last;

    assign i_r       = reset_n & ~r_full[r_wptr];
    assign o_v       = reset_n & r_full[r_rptr];
    assign o_last    = o_v & (r_col == c_col_last);

    assign w_wr      = i_v & i_r;
    assign w_rd      = o_v & o_r;
    assign w_wr_last = w_wr & (r_row == c_row_last);
    assign w_rd_last = w_rd & (r_col == c_col_last);

    // Pointers, counters and full flags. A bank can only be filled while it
    // is empty and only drained while it is full, so the set and clear of the
    // full flags never target the same bank in one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_full <= 2'b00;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_row  <= '0;
            r_col  <= '0;
        end else begin
            if (w_wr) begin
                if (w_wr_last) begin
                    r_row  <= '0;
                    r_wptr <= ~r_wptr;
                end else begin
                    r_row  <= r_row + c_row_one;
                end
            end

            if (w_rd) begin
                if (w_rd_last) begin
                    r_col  <= '0;
                    r_rptr <= ~r_rptr;
                end else begin
                    r_col  <= r_col + c_col_one;
                end
            end

            if (w_wr_last) begin
                r_full[r_wptr] <= 1'b1;
            end
            if (w_rd_last) begin
                r_full[r_rptr] <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset; the full flags gate its use.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int r = 0; r < rs; r++) begin
                if (r_row == c_rw'(r)) begin
                    for (int c = 0; c < cs; c++) begin
                        r_mem[r_wptr][r][c] <= i_d[c*w +: w];
                    end
                end
            end
        end
    end

    generate
        for (genvar gr = 0; gr < rs; gr++) begin : g_row
            logic [0:w-1] w_elem;

            always_comb begin
                w_elem = '0;
                for (int c = 0; c < cs; c++) begin
                    if (r_col == c_cw'(c)) begin
                        w_elem = r_mem[r_rptr][gr][c];
                    end
                end
            end

            assign o_d[gr*w +: w] = w_elem;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_base_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_base_transpose_stream
// Description : Scoreboard bench for base_transpose_stream in three shapes.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_base_transpose_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // a: w=8 rs=2 cs=3
    logic        iv_a, ir_a, ov_a, or_a, last_a;
    logic [0:23] id_a;
    logic [0:15] od_a;
    // b: w=8 rs=2 cs=2
    logic        iv_b, ir_b, ov_b, or_b, last_b;
    logic [0:15] id_b;
    logic [0:15] od_b;
    // c: w=8 rs=1 cs=4
    logic        iv_c, ir_c, ov_c, or_c, last_c;
    logic [0:31] id_c;
    logic [0:7]  od_c;

    base_transpose_stream #(.w(8), .rs(2), .cs(3)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_v(iv_a), .i_r(ir_a), .i_d(id_a),
        .o_v(ov_a), .o_r(or_a), .o_d(od_a), .o_last(last_a));
    base_transpose_stream #(.w(8), .rs(2), .cs(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_v(iv_b), .i_r(ir_b), .i_d(id_b),
        .o_v(ov_b), .o_r(or_b), .o_d(od_b), .o_last(last_b));
    base_transpose_stream #(.w(8), .rs(1), .cs(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .i_v(iv_c), .i_r(ir_c), .i_d(id_c),
        .o_v(ov_c), .o_r(or_c), .o_d(od_c), .o_last(last_c));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [0:15] qa_d [$];
    bit          qa_l [$];
    logic [0:15] qb_d [$];
    bit          qb_l [$];
    logic [0:7]  qc_d [$];
    bit          qc_l [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected columns are queued when the matrix is handed to the stimulus.
    task automatic push_a(input logic [0:23] r0, input logic [0:23] r1);
        for (int c = 0; c < 3; c++) begin
            qa_d.push_back({r0[c*8 +: 8], r1[c*8 +: 8]});
            qa_l.push_back(c == 2);
        end
    endtask

    task automatic push_b(input logic [0:15] r0, input logic [0:15] r1);
        for (int c = 0; c < 2; c++) begin
            qb_d.push_back({r0[c*8 +: 8], r1[c*8 +: 8]});
            qb_l.push_back(c == 1);
        end
    endtask

    task automatic push_c(input logic [0:31] r0);
        for (int c = 0; c < 4; c++) begin
            qc_d.push_back(r0[c*8 +: 8]);
            qc_l.push_back(c == 3);
        end
    endtask

    always @(negedge clk) begin
        if (ov_a === 1'b1 && or_a === 1'b1) begin
            chk("a_col_expected", 32'(qa_d.size() > 0), 32'd1);
            if (qa_d.size() > 0) begin
                chk("a_col_data", 32'(od_a), 32'(qa_d.pop_front()));
                chk("a_col_last", 32'(last_a), 32'(qa_l.pop_front()));
            end
        end
        if (ov_b === 1'b1 && or_b === 1'b1) begin
            chk("b_col_expected", 32'(qb_d.size() > 0), 32'd1);
            if (qb_d.size() > 0) begin
                chk("b_col_data", 32'(od_b), 32'(qb_d.pop_front()));
                chk("b_col_last", 32'(last_b), 32'(qb_l.pop_front()));
            end
        end
        if (ov_c === 1'b1 && or_c === 1'b1) begin
            chk("c_col_expected", 32'(qc_d.size() > 0), 32'd1);
            if (qc_d.size() > 0) begin
                chk("c_col_data", 32'(od_c), 32'(qc_d.pop_front()));
                chk("c_col_last", 32'(last_c), 32'(qc_l.pop_front()));
            end
        end
    end

    task automatic send_a(input logic [0:23] d, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        iv_a = 1'b1;
        id_a = d;
        while (!acc && stalls < 200) begin
            @(negedge clk);
            acc = ir_a;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
        end
        chk("a_row_accepted", 32'(acc), 32'd1);
        iv_a = 1'b0;
        id_a = 'x;
    endtask

    task automatic send_b(input logic [0:15] d, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        iv_b = 1'b1;
        id_b = d;
        while (!acc && stalls < 200) begin
            @(negedge clk);
            acc = ir_b;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
        end
        chk("b_row_accepted", 32'(acc), 32'd1);
        iv_b = 1'b0;
        id_b = 'x;
    endtask

    task automatic send_c(input logic [0:31] d, output int stalls);
        bit acc = 1'b0;
        stalls = 0;
        iv_c = 1'b1;
        id_c = d;
        while (!acc && stalls < 200) begin
            @(negedge clk);
            acc = ir_c;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
        end
        chk("c_row_accepted", 32'(acc), 32'd1);
        iv_c = 1'b0;
        id_c = 'x;
    endtask

    function automatic int qsize(input int which);
        case (which)
            0:       return qa_d.size();
            1:       return qb_d.size();
            default: return qc_d.size();
        endcase
    endfunction

    task automatic wait_drain(input int which);
        int n = 0;
        while (qsize(which) > 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_complete", 32'(qsize(which)), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit          rnd_run;
    logic [0:15] rr0, rr1;
    int          st, st_sum;

    initial begin
        reset_n = 1'b0;
        iv_a = 1'b0; or_a = 1'b0; id_a = '0;
        iv_b = 1'b0; or_b = 1'b0; id_b = '0;
        iv_c = 1'b0; or_c = 1'b0; id_c = '0;
        rnd_run = 1'b0;

        // reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ir_a", 32'(ir_a), 32'd0);
        chk("rst_ov_a", 32'(ov_a), 32'd0);
        chk("rst_last_a", 32'(last_a), 32'd0);
        chk("rst_ir_b", 32'(ir_b), 32'd0);
        chk("rst_ov_b", 32'(ov_b), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ir_a", 32'(ir_a), 32'd1);
        chk("post_rst_ir_b", 32'(ir_b), 32'd1);
        chk("post_rst_ir_c", 32'(ir_c), 32'd1);
        tick();

        // 2x3 transpose with one-cycle latency
        or_a = 1'b1;
        push_a(24'h010203, 24'h040506);
        send_a(24'h010203, st);
        @(negedge clk);
        chk("a_ov_after_row0", 32'(ov_a), 32'd0);
        tick();
        send_a(24'h040506, st);
        @(negedge clk);
        chk("a_ov_latency", 32'(ov_a), 32'd1);
        wait_drain(0);
        @(negedge clk);
        chk("a_ov_idle", 32'(ov_a), 32'd0);
        tick();

        // 2x2 back-to-back streaming
        or_b = 1'b1;
        push_b(16'h0102, 16'h0304);
        push_b(16'h0506, 16'h0708);
        st_sum = 0;
        send_b(16'h0102, st); st_sum += st;
        send_b(16'h0304, st); st_sum += st;
        send_b(16'h0506, st); st_sum += st;
        send_b(16'h0708, st); st_sum += st;
        chk("b_stream_stalls", 32'(st_sum), 32'd0);
        @(negedge clk);
        chk("b_stream_ov0", 32'(ov_b), 32'd1);
        tick();
        @(negedge clk);
        chk("b_stream_ov1", 32'(ov_b), 32'd1);
        tick();
        @(negedge clk);
        chk("b_stream_ov_end", 32'(ov_b), 32'd0);
        chk("b_stream_queue", 32'(qb_d.size()), 32'd0);
        tick();

        // backpressure: two matrices buffered, third blocked
        or_b = 1'b0;
        push_b(16'h1112, 16'h1314);
        push_b(16'h2122, 16'h2324);
        push_b(16'h3132, 16'h3334);
        st_sum = 0;
        send_b(16'h1112, st); st_sum += st;
        send_b(16'h1314, st); st_sum += st;
        send_b(16'h2122, st); st_sum += st;
        send_b(16'h2324, st); st_sum += st;
        chk("b_bp_fill_stalls", 32'(st_sum), 32'd0);
        iv_b = 1'b1;
        id_b = 16'h3132;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_bp_ir_low", 32'(ir_b), 32'd0);
            chk("b_bp_hold_od", 32'(od_b), 32'h1113);
            chk("b_bp_hold_last", 32'(last_b), 32'd0);
            tick();
        end
        or_b = 1'b1;
        @(negedge clk);
        chk("b_bp_ir_col0", 32'(ir_b), 32'd0);
        tick();
        @(negedge clk);
        chk("b_bp_ir_col1", 32'(ir_b), 32'd0);
        tick();
        @(negedge clk);
        chk("b_bp_ir_rise", 32'(ir_b), 32'd1);
        tick();
        send_b(16'h3334, st);
        wait_drain(1);

        // reset after a partial fill
        send_b(16'h4142, st);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("b_rst_fill_ov", 32'(ov_b), 32'd0);
        chk("b_rst_fill_ir", 32'(ir_b), 32'd1);
        tick();
        push_b(16'h5152, 16'h5354);
        send_b(16'h5152, st);
        send_b(16'h5354, st);
        wait_drain(1);

        // reset in the middle of a drain
        or_b = 1'b0;
        push_b(16'h6162, 16'h6364);
        send_b(16'h6162, st);
        send_b(16'h6364, st);
        or_b = 1'b1;
        tick();
        or_b = 1'b0;
        reset_n = 1'b0;
        qb_d.delete();
        qb_l.delete();
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("b_rst_drain_ov", 32'(ov_b), 32'd0);
        chk("b_rst_drain_ir", 32'(ir_b), 32'd1);
        chk("b_rst_drain_last", 32'(last_b), 32'd0);
        tick();
        or_b = 1'b1;
        push_b(16'h7172, 16'h7374);
        send_b(16'h7172, st);
        send_b(16'h7374, st);
        wait_drain(1);

        // single-row matrices
        or_c = 1'b1;
        push_c(32'h0A0B0C0D);
        send_c(32'h0A0B0C0D, st);
        @(negedge clk);
        chk("c_ov_latency", 32'(ov_c), 32'd1);
        wait_drain(2);
        or_c = 1'b0;
        push_c(32'h1A1B1C1D);
        push_c(32'h2A2B2C2D);
        send_c(32'h1A1B1C1D, st);
        send_c(32'h2A2B2C2D, st);
        chk("c_two_banks_stalls", 32'(st), 32'd0);
        @(negedge clk);
        chk("c_full_ir", 32'(ir_c), 32'd0);
        chk("c_hold_od", 32'(od_c), 32'h1A);
        tick();
        or_c = 1'b1;
        wait_drain(2);

        // random valid/ready traffic, 1000 matrices
        rnd_run = 1'b1;
        fork
            begin
                while (rnd_run) begin
                    or_b = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join_none
        for (int m = 0; m < 1000; m++) begin
            rr0 = 16'($urandom);
            rr1 = 16'($urandom);
            push_b(rr0, rr1);
            repeat ($urandom_range(0, 2)) tick();
            send_b(rr0, st);
            repeat ($urandom_range(0, 1)) tick();
            send_b(rr1, st);
        end
        wait_drain(1);
        rnd_run = 1'b0;
        tick();
        tick();
        or_b = 1'b0;

        chk("final_queue_a", 32'(qa_d.size()), 32'd0);
        chk("final_queue_b", 32'(qb_d.size()), 32'd0);
        chk("final_queue_c", 32'(qc_d.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
